c_ctrl_skid_stage: RTL and testbench
====================================

# c_ctrl_skid_stage

Parametrised control-bundle pipeline stage with valid/ready handshake, 2-entry skid buffer, external stall, flush-to-bubble and saturating stall/squash counters. It is the next-generation replacement for fixed-field inter-stage control registers (ID/EX, EX/MEM), so back-pressure can propagate without combinational ready paths. One instance is placed per pipeline boundary, with the bundle carried as an opaque `WIDTH`-bit vector.

## Interface
- `WIDTH`, 14: control bundle width in bits.
- `BUBBLE`, 14'h0800: `WIDTH`-bit NOP pattern (default sets only OpBSrc); loaded into every vacated entry.
- `CNT_W`, 16: width of each performance counter.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream bundle valid.
- `in_ready` output 1: stage can accept this cycle.
- `in_data` input `WIDTH`: upstream bundle.
- `stall_i` input 1: hazard-unit stall; freezes the stage.
- `flush_i` input 1: squash all held bundles; priority over stall.
- `out_valid` output 1: downstream bundle valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output `WIDTH`: downstream bundle; equals `BUBBLE` when the main entry is invalid.
- `clr_cnt` input 1: synchronous clear of both counters.
- `stall_cnt` output `CNT_W`: saturating count of stalled/back-pressured cycles.
- `squash_cnt` output `CNT_W`: saturating count of valid bundles discarded by flush.

## Operation
- State: main entry (`m_valid`, `m_data`) drives the outputs; skid entry (`s_valid`, `s_data`).
- `in_ready = !s_valid && !stall_i && !flush_i`.
- `out_valid = m_valid && !stall_i`. `out_data = m_data`.
- `push = in_valid && in_ready`. `pop = out_valid && out_ready`.
- Flush: both entries are set invalid and both data registers are set to `BUBBLE`. The `in_data` presented that cycle is dropped. `squash_cnt` increases by `m_valid + s_valid` (0..2).
- Stall without flush: all entries are held and no push or pop occurs.
- Otherwise, one of the following applies:
  - No pop, push, main empty: the bundle loads into main.
  - No pop, push, main full: the bundle loads into skid. `in_ready` is 0 from the next cycle.
  - Pop, skid full: skid moves to main. Skid becomes invalid and its data becomes `BUBBLE`. No push occurs, since `in_ready` is 0.
  - Pop, skid empty, push: the new bundle loads into main.
  - Pop, skid empty, no push: main becomes invalid and its data becomes `BUBBLE`.
- Ordering is strictly FIFO. No bundle is ever duplicated or lost except through flush.
- `stall_cnt` increments in any cycle with `stall_i`, or with `m_valid && !out_ready`. This applies only when `flush_i` is low.
- Both counters saturate at all-ones.
- `clr_cnt` has priority over any increment in the same cycle; the counter reads 0 next cycle.
- Reset value of every output:
  - `in_ready` is 1 if `stall_i` and `flush_i` are low.
  - `out_valid` is 0.
  - `out_data` is `BUBBLE`.
  - Both counters are 0.
- Reset asserted mid-operation discards all entries immediately (asynchronously).

## Timing
- Latency: 1 cycle from push into an empty stage to `out_valid`.
- Throughput: 1 bundle per cycle with `out_ready` held high.
- `in_ready` depends only on registered `s_valid` plus `stall_i` and `flush_i`. There is no path from `out_ready` to `in_ready`.
- `flush_i` takes effect at the next clock edge. `out_valid` is 0 in the cycle after the flush.
- `stall_i` masks `out_valid` and `in_ready` combinationally in the same cycle.
- Counters update at the clock edge and are visible the next cycle.

## Structure
- Shared package `c_pipe_pkg` holds:
  - The packed struct `id_ex_ctrl_t`, MSB to LSB: RegWE_E, RegWE_W, OpBSrc, MemWrite, branch, jump, ExPath[1:0], ALUFunc[2:0], funct3[2:0]. This totals 14 bits.
  - The constants `ID_EX_CTRL_W` = 14 and `ID_EX_BUBBLE` = 14'h0800.
- Sub-module `c_sat_counter` (parameter `CNT_W`; inputs `clr`, `inc[1:0]`; saturating) is instantiated twice.

## Test plan
- Reset, then a single push of 14'h1234 with `out_ready`=1: `out_valid` is 1 for one cycle with `out_data`=14'h1234, then 0 with data 14'h0800.
- Stream 14'h0001..14'h0008 back-to-back, `out_ready` low on cycles 3-4:
  - `in_ready` drops one cycle after main and skid are full.
  - The output order is exactly 1..8.
  - `stall_cnt`=2.
- Main and skid full with 14'h00AA and 14'h00BB, then `flush_i` for 1 cycle:
  - Next cycle `out_valid`=0 and `out_data`=14'h0800.
  - `squash_cnt`=2.
  - The input offered during the flush is absent from the output.
- `stall_i` and `flush_i` together with main full: the flush wins, with `squash_cnt`+1 and `stall_cnt` unchanged.
- `stall_i` for 3 cycles with main holding 14'h0F0F and `out_ready`=1:
  - `out_valid`=0 and `in_ready`=0 throughout.
  - 14'h0F0F is delivered on the first unstalled cycle.
  - `stall_cnt`=3.
- With `CNT_W`=4, hold back-pressure for 20 cycles: `stall_cnt` stops at 4'hF. `clr_cnt` during a back-pressured cycle gives 0 next cycle. `reset_n` low mid-stream clears the entries asynchronously and zeroes both counters.

Source files
------------

// File: rtl/c_pipe_pkg.sv
// Shared pipeline-control definitions: ID/EX control bundle layout and its NOP pattern.
package c_pipe_pkg;

    localparam int unsigned ID_EX_CTRL_W = 14;

    // MSB to LSB; a bubble sets only OpBSrc so the operand mux stays in a benign position.
    typedef struct packed {
        logic       RegWE_E;
        logic       RegWE_W;
        logic       OpBSrc;
        logic       MemWrite;
        logic       branch;
        logic       jump;
        logic [1:0] ExPath;
        logic [2:0] ALUFunc;
        logic [2:0] funct3;
    } id_ex_ctrl_t;

    localparam logic [ID_EX_CTRL_W-1:0] ID_EX_BUBBLE = 14'h0800;

endpackage

// File: rtl/c_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over any increment.
module c_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;

    // One extra bit catches the wrap so the result can be clamped to all-ones.
    always_comb begin
        w_sum = {1'b0, r_cnt} + {{(CNT_W-1){1'b0}}, inc};
    end

    // Counter register: clear, else clamp on overflow, else add.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_sum[CNT_W]) begin
            r_cnt <= '1;
        end else begin
            r_cnt <= w_sum[CNT_W-1:0];
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/c_ctrl_skid_stage.sv
// Control-bundle pipeline stage: main + skid entry, stall freeze, flush to bubble,
// stall and squash performance counters. in_ready never sees out_ready.
module c_ctrl_skid_stage
    import c_pipe_pkg::*;
#(
    parameter int unsigned             WIDTH  = ID_EX_CTRL_W,
    parameter logic [WIDTH-1:0]        BUBBLE = ID_EX_BUBBLE,
    parameter int unsigned             CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_data;

    logic             w_m_valid_nxt;
    logic [WIDTH-1:0] w_m_data_nxt;
    logic             w_s_valid_nxt;
    logic [WIDTH-1:0] w_s_data_nxt;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_stall_inc;
    logic [1:0]       w_squash_inc;

    assign in_ready  = !r_s_valid && !stall_i && !flush_i;
    assign out_valid = r_m_valid && !stall_i;
    assign out_data  = r_m_data;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Next-state of the two entries; flush beats stall, stall holds everything.
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_data_nxt  = r_m_data;
        w_s_valid_nxt = r_s_valid;
        w_s_data_nxt  = r_s_data;
        if (flush_i) begin
            w_m_valid_nxt = 1'b0;
            w_m_data_nxt  = BUBBLE;
            w_s_valid_nxt = 1'b0;
            w_s_data_nxt  = BUBBLE;
        end else if (!stall_i) begin
            if (w_pop) begin
                if (r_s_valid) begin
                    // in_ready is low while skid is full, so no push can collide here.
                    w_m_data_nxt  = r_s_data;
                    w_s_valid_nxt = 1'b0;
                    w_s_data_nxt  = BUBBLE;
                end else if (w_push) begin
                    w_m_data_nxt  = in_data;
                end else begin
                    w_m_valid_nxt = 1'b0;
                    w_m_data_nxt  = BUBBLE;
                end
            end else if (w_push) begin
                if (!r_m_valid) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_data_nxt  = in_data;
                end else begin
                    w_s_valid_nxt = 1'b1;
                    w_s_data_nxt  = in_data;
                end
            end
        end
    end

    // Entry registers; reset empties both entries and parks the data at the bubble pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= BUBBLE;
            r_s_valid <= 1'b0;
            r_s_data  <= BUBBLE;
        end else begin
            r_m_valid <= w_m_valid_nxt;
            r_m_data  <= w_m_data_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_s_data  <= w_s_data_nxt;
        end
    end

    // Counter increments: a flushed cycle counts only as squash, never as stall.
    always_comb begin
        w_stall_inc  = {1'b0, !flush_i && (stall_i || (r_m_valid && !out_ready))};
        w_squash_inc = 2'd0;
        if (flush_i) begin
            w_squash_inc = {1'b0, r_m_valid} + {1'b0, r_s_valid};
        end
    end

    c_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (w_stall_inc),
        .cnt     (stall_cnt)
    );

    c_sat_counter #(.CNT_W(CNT_W)) u_squash_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (w_squash_inc),
        .cnt     (squash_cnt)
    );

endmodule

// File: tb/tb_c_ctrl_skid_stage.sv
// Bench for c_ctrl_skid_stage: two instances (16-bit and 4-bit counters) share stimulus;
// a queue scoreboard tracks accepted bundles and checks delivery order.
module tb_c_ctrl_skid_stage;

    localparam int W = 14;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b1;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         stall_i   = 1'b0;
    logic         flush_i   = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_cnt   = 1'b0;

    logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [W-1:0] out_data_a, out_data_b;
    logic [15:0]  stall_cnt_a, squash_cnt_a;
    logic [3:0]   stall_cnt_b, squash_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [W-1:0] sb_q[$];

    c_ctrl_skid_stage #(.CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .stall_i(stall_i), .flush_i(flush_i), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .clr_cnt(clr_cnt),
        .stall_cnt(stall_cnt_a), .squash_cnt(squash_cnt_a)
    );

    c_ctrl_skid_stage #(.CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .stall_i(stall_i), .flush_i(flush_i), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .clr_cnt(clr_cnt),
        .stall_cnt(stall_cnt_b), .squash_cnt(squash_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
        end else if (flush_i) begin
            sb_q.delete();
        end else begin
            if (out_valid_a && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_out", {18'd0, out_data_a}, 32'hFFFF_FFFF);
                end else begin
                    logic [W-1:0] exp_d;
                    exp_d = sb_q.pop_front();
                    chk("sb_data_a", {18'd0, out_data_a}, {18'd0, exp_d});
                    chk("sb_data_b", {18'd0, out_data_b}, {18'd0, exp_d});
                    n_pop++;
                end
            end
            if (in_valid && in_ready_a) sb_q.push_back(in_data);
        end
    end

    initial begin
        int idx;
        int pop0;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_data", out_data_a, 32'h0800);
        chk("rst_stall_cnt", stall_cnt_a, 0);
        chk("rst_squash_cnt", squash_cnt_a, 0);
        tick();
        tick();
        reset_n = 1'b1;

        // Single push, one-cycle latency, then bubble
        in_valid = 1'b1; in_data = 14'h1234; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("t1_out_valid", out_valid_a, 1);
        chk("t1_out_data", out_data_a, 32'h1234);
        tick();
        #1;
        chk("t1_out_valid_after", out_valid_a, 0);
        chk("t1_out_data_after", out_data_a, 32'h0800);

        // Stream 1..8 with back-pressure on cycles 3-4
        pop0 = n_pop;
        idx  = 1;
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c == 3 || c == 4);
            in_valid  = (idx <= 8);
            in_data   = W'(idx);
            #1;
            if (c == 3) chk("t2_in_ready_c3", in_ready_a, 1);
            if (c == 4) chk("t2_in_ready_c4", in_ready_a, 0);
            if (in_valid && in_ready_a) idx++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("t2_pop_count", n_pop - pop0, 8);
        chk("t2_queue_empty", sb_q.size(), 0);
        chk("t2_stall_cnt", stall_cnt_a, 2);

        // Fill main and skid, then flush
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 14'h00AA;
        tick();
        in_data = 14'h00BB;
        tick();
        #1;
        chk("t3_full_in_ready", in_ready_a, 0);
        in_data = 14'h00CC; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; in_valid = 1'b0;
        #1;
        chk("t3_out_valid", out_valid_a, 0);
        chk("t3_out_data", out_data_a, 32'h0800);
        chk("t3_squash_cnt", squash_cnt_a, 2);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t3_stays_empty", out_valid_a, 0);

        // Stall and flush together: flush wins
        clr_cnt = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 14'h00DD;
        tick();
        clr_cnt = 1'b0; in_valid = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("t4_masked_valid", out_valid_a, 0);
        tick();
        stall_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("t4_squash_cnt", squash_cnt_a, 1);
        chk("t4_stall_cnt", stall_cnt_a, 0);
        chk("t4_out_valid", out_valid_a, 0);

        // Stall for 3 cycles with main holding 0F0F
        clr_cnt = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 14'h0F0F;
        tick();
        clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_out_valid", out_valid_a, 0);
            chk("t5_stall_in_ready", in_ready_a, 0);
            tick();
        end
        stall_i = 1'b0;
        #1;
        chk("t5_out_valid", out_valid_a, 1);
        chk("t5_out_data", out_data_a, 32'h0F0F);
        chk("t5_stall_cnt", stall_cnt_a, 3);
        tick();

        // Counter saturation, clear under back-pressure, async reset mid-stream
        clr_cnt = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 14'h0055;
        tick();
        clr_cnt = 1'b0; in_valid = 1'b0;
        repeat (20) tick();
        chk("t6_sat_b", stall_cnt_b, 32'hF);
        chk("t6_cnt_a", stall_cnt_a, 20);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        #1;
        chk("t6_clr_a", stall_cnt_a, 0);
        chk("t6_clr_b", stall_cnt_b, 0);
        in_valid = 1'b1; in_data = 14'h0066;
        tick();
        in_valid = 1'b0;
        #1;
        chk("t6_recount_a", stall_cnt_a, 1);
        chk("t6_skid_full", in_ready_a, 0);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid_a, 0);
        chk("t6_rst_out_data", out_data_a, 32'h0800);
        chk("t6_rst_in_ready", in_ready_a, 1);
        chk("t6_rst_stall_a", stall_cnt_a, 0);
        chk("t6_rst_stall_b", stall_cnt_b, 0);
        tick();
        reset_n = 1'b1; in_valid = 1'b1; in_data = 14'h0077; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("t6_post_rst_valid", out_valid_a, 1);
        chk("t6_post_rst_data", out_data_a, 32'h0077);
        tick();
        #1;
        chk("t6_post_rst_empty", out_valid_a, 0);
        chk("t6_final_queue", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
